// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// mem_arbiter : round-robin arbiter sharing one single-port word memory
//               between instruction fetch (A, read-only) and load/store (B).
// Revision    : 1.0
// =============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  a_req_valid,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    output logic                  a_req_ready,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    output logic                  a_rsp_err,

    input  logic                  b_req_valid,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic                  b_req_we,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_req_ready,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic                  b_rsp_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    port_t r_last_grant;

    logic w_grant_a;
    logic w_grant_b;
    logic w_xfer_a;
    logic w_xfer_b;
    logic w_a_misaligned;
    logic w_b_misaligned;

    assign w_a_misaligned = |a_req_addr[1:0];
    assign w_b_misaligned = |b_req_addr[1:0];

    // On contention the port that did not win last time is served.
    assign w_grant_a = a_req_valid && (!b_req_valid || (r_last_grant == PORT_B));
    assign w_grant_b = b_req_valid && (!a_req_valid || (r_last_grant == PORT_A));

    // Externally visible grants are suppressed while reset is held; the
    // flops below are already forced by reset, so they use the raw grants.
    assign w_xfer_a = w_grant_a && rst_n;
    assign w_xfer_b = w_grant_b && rst_n;

    assign a_req_ready = w_xfer_a;
    assign b_req_ready = w_xfer_b;

    always_comb begin
        mem_addr         = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;
        if (w_xfer_a) begin
            mem_addr = a_req_addr;
        end else if (w_xfer_b) begin
            mem_addr         = b_req_addr;
            mem_data_in      = b_req_wdata;
            mem_write_enable = b_req_we && !w_b_misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_B;
            a_rsp_valid  <= 1'b0;
            a_rsp_data   <= '0;
            a_rsp_err    <= 1'b0;
            b_rsp_valid  <= 1'b0;
            b_rsp_data   <= '0;
            b_rsp_err    <= 1'b0;
        end else begin
            a_rsp_valid <= w_grant_a;
            b_rsp_valid <= w_grant_b;

            if (w_grant_a) begin
                r_last_grant <= PORT_A;
                a_rsp_err    <= w_a_misaligned;
                a_rsp_data   <= w_a_misaligned ? '0 : mem_data_out;
            end

            // Writes and misaligned accesses answer with zero data.
            if (w_grant_b) begin
                r_last_grant <= PORT_B;
                b_rsp_err    <= w_b_misaligned;
                b_rsp_data   <= (b_req_we || w_b_misaligned) ? '0 : mem_data_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_arbiter : directed vector table, reset corner case and randomized
//                  traffic against a behavioural arbiter/memory model.
// Revision       : 1.0
// =============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req_valid;
    logic [7:0]  a_req_addr;
    logic        a_req_ready;
    logic        a_rsp_valid;
    logic [31:0] a_rsp_data;
    logic        a_rsp_err;
    logic        b_req_valid;
    logic [7:0]  b_req_addr;
    logic        b_req_we;
    logic [31:0] b_req_wdata;
    logic        b_req_ready;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic        b_rsp_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_enable;
    logic [31:0] mem_data_out;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .a_req_valid      (a_req_valid),
        .a_req_addr       (a_req_addr),
        .a_req_ready      (a_req_ready),
        .a_rsp_valid      (a_rsp_valid),
        .a_rsp_data       (a_rsp_data),
        .a_rsp_err        (a_rsp_err),
        .b_req_valid      (b_req_valid),
        .b_req_addr       (b_req_addr),
        .b_req_we         (b_req_we),
        .b_req_wdata      (b_req_wdata),
        .b_req_ready      (b_req_ready),
        .b_rsp_valid      (b_rsp_valid),
        .b_rsp_data       (b_rsp_data),
        .b_rsp_err        (b_rsp_err),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The memory instance the arbiter drives: combinational read, clocked write.
    logic [31:0] mem_array [0:63];
    assign mem_data_out = mem_array[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write_enable) mem_array[mem_addr[7:2]] <= mem_data_in;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_last;          // 0: A served last, 1: B served last
    logic [31:0] ref_mem [0:63];
    logic        m_a_v, m_a_err, m_b_v, m_b_err;
    logic [31:0] m_a_data, m_b_data;

    // Values observed by the last step
    logic        s_a_ready, s_b_ready, s_we;
    logic        s_a_v, s_a_err, s_b_v, s_b_err;
    logic [31:0] s_a_data, s_b_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last   = 1;
        m_a_v    = 1'b0;
        m_a_err  = 1'b0;
        m_a_data = 32'h0;
        m_b_v    = 1'b0;
        m_b_err  = 1'b0;
        m_b_data = 32'h0;
    endtask

    task automatic drive(input logic av, input logic [7:0] aa, input logic bv,
                         input logic [7:0] ba, input logic bwe, input logic [31:0] bwd);
        a_req_valid = av;
        a_req_addr  = aa;
        b_req_valid = bv;
        b_req_addr  = ba;
        b_req_we    = bwe;
        b_req_wdata = bwd;
    endtask

    // One clock: check request-side outputs mid-cycle, advance the model,
    // then check responses just after the rising edge.
    task automatic step();
        logic ga, gb, exp_we;
        logic [7:0] exp_addr;
        @(negedge clk);
        ga = 1'b0;
        gb = 1'b0;
        if (rst_n) begin
            if (a_req_valid && b_req_valid) begin
                if (m_last == 1) ga = 1'b1; else gb = 1'b1;
            end else begin
                ga = a_req_valid;
                gb = b_req_valid;
            end
        end
        exp_we   = gb && b_req_we && (b_req_addr[1:0] == 2'b00);
        exp_addr = ga ? a_req_addr : (gb ? b_req_addr : 8'h00);
        s_a_ready = a_req_ready;
        s_b_ready = b_req_ready;
        s_we      = mem_write_enable;
        chk("a_req_ready", a_req_ready, ga);
        chk("b_req_ready", b_req_ready, gb);
        chk("mem_write_enable", mem_write_enable, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        if (gb) chk("mem_data_in", mem_data_in, b_req_wdata);

        if (!rst_n) model_reset();
        m_a_v = 1'b0;
        m_b_v = 1'b0;
        if (ga) begin
            m_last   = 0;
            m_a_v    = 1'b1;
            m_a_err  = (a_req_addr[1:0] != 2'b00);
            m_a_data = m_a_err ? 32'h0 : ref_mem[a_req_addr / 4];
        end
        if (gb) begin
            m_last   = 1;
            m_b_v    = 1'b1;
            m_b_err  = (b_req_addr[1:0] != 2'b00);
            m_b_data = (b_req_we || m_b_err) ? 32'h0 : ref_mem[b_req_addr / 4];
            if (b_req_we && !m_b_err) ref_mem[b_req_addr / 4] = b_req_wdata;
        end

        @(posedge clk);
        #1;
        s_a_v = a_rsp_valid; s_a_data = a_rsp_data; s_a_err = a_rsp_err;
        s_b_v = b_rsp_valid; s_b_data = b_rsp_data; s_b_err = b_rsp_err;
        chk("a_rsp_valid", a_rsp_valid, m_a_v);
        chk("a_rsp_data", a_rsp_data, m_a_data);
        chk("a_rsp_err", a_rsp_err, m_a_err);
        chk("b_rsp_valid", b_rsp_valid, m_b_v);
        chk("b_rsp_data", b_rsp_data, m_b_data);
        chk("b_rsp_err", b_rsp_err, m_b_err);
    endtask

    typedef struct {
        logic        av;
        logic [7:0]  aa;
        logic        bv;
        logic [7:0]  ba;
        logic        bwe;
        logic [31:0] bwd;
        logic        ar, br, we;
        logic        arv;
        logic [31:0] ard;
        logic        are;
        logic        brv;
        logic [31:0] brd;
        logic        bre;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [7:0] aa, input logic bv,
                                input logic [7:0] ba, input logic bwe, input logic [31:0] bwd,
                                input logic ar, input logic br, input logic we,
                                input logic arv, input logic [31:0] ard, input logic are,
                                input logic brv, input logic [31:0] brd, input logic bre);
        vec_t v;
        v.av = av; v.aa = aa; v.bv = bv; v.ba = ba; v.bwe = bwe; v.bwd = bwd;
        v.ar = ar; v.br = br; v.we = we;
        v.arv = arv; v.ard = ard; v.are = are;
        v.brv = brv; v.brd = brd; v.bre = bre;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        logic        hold_a, hold_b;
        string       tag;
        for (int i = 0; i < 64; i++) begin
            mem_array[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        model_reset();

        //            A req           B req                              rdy A,B,we  A rsp                  B rsp
        tbl[0]  = mk(0, 8'h00, 1, 8'h00, 1, 32'hdeadbeef, 0, 1, 1, 0, 32'h0,        0, 1, 32'h0,        0);
        tbl[1]  = mk(1, 8'h00, 0, 8'h00, 0, 32'h0,        1, 0, 0, 1, 32'hdeadbeef, 0, 0, 32'h0,        0);
        tbl[2]  = mk(0, 8'h00, 1, 8'h04, 1, 32'hcafebabe, 0, 1, 1, 0, 32'hdeadbeef, 0, 1, 32'h0,        0);
        tbl[3]  = mk(1, 8'h00, 1, 8'h04, 0, 32'h0,        1, 0, 0, 1, 32'hdeadbeef, 0, 0, 32'h0,        0);
        tbl[4]  = mk(1, 8'h00, 1, 8'h04, 0, 32'h0,        0, 1, 0, 0, 32'hdeadbeef, 0, 1, 32'hcafebabe, 0);
        tbl[5]  = mk(1, 8'h00, 1, 8'h04, 0, 32'h0,        1, 0, 0, 1, 32'hdeadbeef, 0, 0, 32'hcafebabe, 0);
        tbl[6]  = mk(1, 8'h00, 1, 8'h04, 0, 32'h0,        0, 1, 0, 0, 32'hdeadbeef, 0, 1, 32'hcafebabe, 0);
        tbl[7]  = mk(0, 8'h00, 1, 8'h02, 1, 32'h11111111, 0, 1, 0, 0, 32'hdeadbeef, 0, 1, 32'h0,        1);
        tbl[8]  = mk(1, 8'h00, 0, 8'h00, 0, 32'h0,        1, 0, 0, 1, 32'hdeadbeef, 0, 0, 32'h0,        1);
        tbl[9]  = mk(0, 8'h00, 1, 8'h04, 1, 32'h22222222, 0, 1, 1, 0, 32'hdeadbeef, 0, 1, 32'h0,        0);
        tbl[10] = mk(0, 8'h00, 1, 8'h04, 0, 32'h0,        0, 1, 0, 0, 32'hdeadbeef, 0, 1, 32'h22222222, 0);
        tbl[11] = mk(1, 8'h05, 0, 8'h00, 0, 32'h0,        1, 0, 0, 1, 32'h0,        1, 0, 32'h22222222, 0);
        tbl[12] = mk(0, 8'h00, 0, 8'h00, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 32'h22222222, 0);
        tbl[13] = mk(1, 8'h00, 1, 8'h04, 0, 32'h0,        0, 1, 0, 0, 32'h0,        1, 1, 32'h22222222, 0);
        tbl[14] = mk(1, 8'h00, 0, 8'h00, 0, 32'h0,        1, 0, 0, 1, 32'hdeadbeef, 0, 0, 32'h22222222, 0);

        // Reset state: no readies even with both requests present.
        rst_n = 1'b0;
        drive(1, 8'h00, 1, 8'h04, 0, 32'h0);
        #1;
        chk("reset a_req_ready", a_req_ready, 1'b0);
        chk("reset b_req_ready", b_req_ready, 1'b0);
        chk("reset a_rsp_valid", a_rsp_valid, 1'b0);
        chk("reset b_rsp_valid", b_rsp_valid, 1'b0);
        chk("reset a_rsp_data", a_rsp_data, 32'h0);
        chk("reset b_rsp_data", b_rsp_data, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].bv, tbl[i].ba, tbl[i].bwe, tbl[i].bwd);
            step();
            tag = $sformatf("vec%0d", i);
            chk({tag, " a_ready"}, s_a_ready, tbl[i].ar);
            chk({tag, " b_ready"}, s_b_ready, tbl[i].br);
            chk({tag, " mem_we"}, s_we, tbl[i].we);
            chk({tag, " a_rsp_valid"}, s_a_v, tbl[i].arv);
            chk({tag, " a_rsp_data"}, s_a_data, tbl[i].ard);
            chk({tag, " a_rsp_err"}, s_a_err, tbl[i].are);
            chk({tag, " b_rsp_valid"}, s_b_v, tbl[i].brv);
            chk({tag, " b_rsp_data"}, s_b_data, tbl[i].brd);
            chk({tag, " b_rsp_err"}, s_b_err, tbl[i].bre);
        end

        // Reset right after a transfer drops the pending response at once.
        drive(1, 8'h00, 0, 8'h00, 0, 32'h0);
        step();
        chk("pre-reset a_rsp_valid", a_rsp_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset a_rsp_valid", a_rsp_valid, 1'b0);
        chk("async reset a_rsp_data", a_rsp_data, 32'h0);
        chk("async reset a_req_ready", a_req_ready, 1'b0);
        model_reset();
        drive(1, 8'h00, 1, 8'h04, 0, 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("post-reset first grant A", s_a_ready, 1'b1);
        chk("post-reset B waits", s_b_ready, 1'b0);
        chk("post-reset a data", s_a_data, 32'hdeadbeef);

        // Randomized traffic; a request not yet accepted is held unchanged.
        hold_a = 1'b0;
        hold_b = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold_a) begin
                a_req_valid = ($urandom_range(0, 3) != 0);
                a_req_addr  = 8'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 4) == 0) a_req_addr[1:0] = 2'($urandom_range(1, 3));
            end
            if (!hold_b) begin
                b_req_valid = ($urandom_range(0, 3) != 0);
                b_req_addr  = 8'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 4) == 0) b_req_addr[1:0] = 2'($urandom_range(1, 3));
                b_req_we    = $urandom_range(0, 1) == 1;
                b_req_wdata = $urandom;
            end
            step();
            hold_a = a_req_valid && !s_a_ready;
            hold_b = b_req_valid && !s_b_ready;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
